// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/response bundle between the fetch unit and imem.
// The fetch unit is the master; the memory model/controller is the slave.
interface pc_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// RV32I fetch stage: PC register, BOOT/FETCH/EXEC sequencer, next-PC select and instruction register.
// Optional fetch watchdog enabled by defining PCFETCH_TIMEOUT_EN.
module pc_fetch_unit #(
    parameter logic [31:0] PC_RESET      = 32'h0000_3000,
    parameter int unsigned FETCH_TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    pc_en,
    input  logic [3:0]              jump_ctrl,
    input  logic                    br_eq,
    input  logic                    br_lt,
    input  logic                    br_ltu,
    input  logic [31:0]             imm,
    input  logic [31:0]             jalr_target,
    pc_fetch_unit_if.master         imem,
    output logic [31:0]             instr,
    output logic                    instr_valid,
    output logic [31:0]             pc,
    output logic [31:0]             pc_plus4,
    output logic                    fetch_err
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic        imem_req_r;
    logic        instr_valid_r;
    logic        req_nxt_s;
    logic        valid_nxt_s;
    logic [31:0] pc_r;
    logic [31:0] instr_r;
    logic [31:0] next_pc_s;
    logic        timeout_hit_s;

    function automatic logic [31:0] calc_next_pc(
        input logic [31:0] cur_pc,
        input logic [3:0]  ctrl,
        input logic        eq,
        input logic        lt,
        input logic        ltu,
        input logic [31:0] offset,
        input logic [31:0] jtarget
    );
        logic [31:0] seq_pc;
        logic [31:0] tgt_pc;
        logic [31:0] result;
        seq_pc = cur_pc + 32'd4;
        tgt_pc = cur_pc + offset;
        case (ctrl)
            4'd0:    result = seq_pc;
            4'd1:    result = tgt_pc;
            4'd2:    result = eq  ? seq_pc : tgt_pc;
            4'd3:    result = eq  ? tgt_pc : seq_pc;
            4'd4:    result = lt  ? tgt_pc : seq_pc;
            4'd5:    result = ltu ? tgt_pc : seq_pc;
            4'd6:    result = jtarget & ~32'h0000_0001;
            default: result = seq_pc;
        endcase
        return result;
    endfunction

    assign next_pc_s = calc_next_pc(pc_r, jump_ctrl, br_eq, br_lt, br_ltu, imm, jalr_target);

    // State register plus the registered handshake outputs derived from the next state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r       <= ST_BOOT;
            imem_req_r    <= 1'b0;
            instr_valid_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            imem_req_r    <= req_nxt_s;
            instr_valid_r <= valid_nxt_s;
        end
    end

    // Next-state selection; a watchdog expiry leaves FETCH exactly like a completed fetch.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_BOOT: begin
                state_nxt_s = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem.imem_ready || timeout_hit_s) begin
                    state_nxt_s = ST_EXEC;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_EXEC: begin
                if (pc_en) begin
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_EXEC;
                end
            end
            default: begin
                state_nxt_s = ST_BOOT;
            end
        endcase
    end

    // Output decode, one cycle ahead so the handshake outputs come straight from flops.
    always_comb begin
        req_nxt_s   = 1'b0;
        valid_nxt_s = 1'b0;
        case (state_nxt_s)
            ST_FETCH: req_nxt_s   = 1'b1;
            ST_EXEC:  valid_nxt_s = 1'b1;
            default: begin
                req_nxt_s   = 1'b0;
                valid_nxt_s = 1'b0;
            end
        endcase
    end

    // PC and instruction register; ready outside FETCH never touches instr.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_r    <= PC_RESET;
            instr_r <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (imem.imem_ready) begin
                        instr_r <= imem.imem_rdata;
                    end else if (timeout_hit_s) begin
                        instr_r <= 32'h0000_0000;
                    end else begin
                        instr_r <= instr_r;
                    end
                end
                ST_EXEC: begin
                    if (pc_en) begin
                        pc_r <= next_pc_s;
                    end else begin
                        pc_r <= pc_r;
                    end
                end
                default: begin
                    pc_r    <= pc_r;
                    instr_r <= instr_r;
                end
            endcase
        end
    end

`ifdef PCFETCH_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(FETCH_TIMEOUT - 1);

    logic [7:0] wait_cnt_r;
    logic       fetch_err_r;

    assign timeout_hit_s = (state_r == ST_FETCH) && !imem.imem_ready && (wait_cnt_r == TIMEOUT_LAST);

    // Wait-cycle counter cleared on FETCH entry; the error flag is sticky until reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wait_cnt_r  <= 8'd0;
            fetch_err_r <= 1'b0;
        end else if (state_r == ST_FETCH) begin
            if (imem.imem_ready) begin
                wait_cnt_r <= wait_cnt_r;
            end else if (wait_cnt_r == TIMEOUT_LAST) begin
                fetch_err_r <= 1'b1;
            end else begin
                wait_cnt_r <= wait_cnt_r + 8'd1;
            end
        end else if (state_nxt_s == ST_FETCH) begin
            wait_cnt_r <= 8'd0;
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    assign fetch_err = fetch_err_r;
`else
    assign timeout_hit_s = 1'b0;
    assign fetch_err     = 1'b0;
`endif

    assign imem.imem_req  = imem_req_r;
    assign imem.imem_addr = {pc_r[31:2], 2'b00};
    assign instr          = instr_r;
    assign instr_valid    = instr_valid_r;
    assign pc             = pc_r;
    assign pc_plus4       = pc_r + 32'd4;

endmodule
